// File: rtl/sqrt_seq_pkg.sv
// Shared constants for the square-root run sequencer: state codes,
// default data-memory addresses and the memory-port grant encoding.
package sqrt_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD_HI = 3'd1;
    localparam state_t ST_LOAD_LO = 3'd2;
    localparam state_t ST_LAUNCH  = 3'd3;
    localparam state_t ST_RUN     = 3'd4;
    localparam state_t ST_READ    = 3'd5;
    localparam state_t ST_RESP    = 3'd6;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_OP_HI_ADDR = 16;
    localparam int DEF_OP_LO_ADDR = 17;
    localparam int DEF_RES_ADDR   = 18;

    localparam logic GNT_SEQ = 1'b0;
    localparam logic GNT_CPU = 1'b1;

endpackage

// File: rtl/sqrt_run_sequencer_dm_port_mux.sv
// Pure 2:1 data-memory port mux; the grant picks whether the sequencer or
// the CPU drives the shared port. Read data always goes back to the CPU.
module dm_port_mux
    import sqrt_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_grant,
    input  logic [ADDR_W-1:0] i_seq_addr,
    input  logic              i_seq_wen,
    input  logic [7:0]        i_seq_wdata,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_wen,
    input  logic [7:0]        i_cpu_wdata,
    input  logic [7:0]        i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [7:0]        o_mem_wdata,
    output logic [7:0]        o_cpu_rdata
);

    assign o_mem_addr  = (i_grant == GNT_CPU) ? i_cpu_addr  : i_seq_addr;
    assign o_mem_wen   = (i_grant == GNT_CPU) ? i_cpu_wen   : i_seq_wen;
    assign o_mem_wdata = (i_grant == GNT_CPU) ? i_cpu_wdata : i_seq_wdata;
    assign o_cpu_rdata = i_mem_rdata;

endmodule

// File: rtl/sqrt_run_sequencer.sv
// Sequences one integer-square-root CPU run per request: load operand,
// pulse Start, wait for Ack or timeout, read the result and hand it back.
module sqrt_run_sequencer
    import sqrt_seq_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int OP_HI_ADDR   = DEF_OP_HI_ADDR,
    parameter int OP_LO_ADDR   = DEF_OP_LO_ADDR,
    parameter int RES_ADDR     = DEF_RES_ADDR,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 65535,
    parameter int CNT_W        = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [15:0]       i_op_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [7:0]        o_res_data,
    output logic              o_res_timeout,
    output logic [CNT_W-1:0]  o_res_cycles,
    output logic              o_busy,
    output logic              o_cpu_reset,
    output logic              o_cpu_start,
    input  logic              i_cpu_ack,
    input  logic [ADDR_W-1:0] i_cpu_dm_addr,
    input  logic              i_cpu_dm_wen,
    input  logic [7:0]        i_cpu_dm_wdata,
    output logic [7:0]        o_cpu_dm_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    localparam int LCH_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [LCH_W-1:0]  LCH_LAST = LCH_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_TO   = CNT_W'(TIMEOUT);

    state_t            r_state;
    logic [15:0]       r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [LCH_W-1:0]  r_lch;
    logic [7:0]        r_res_data;
    logic [CNT_W-1:0]  r_res_cycles;
    logic              r_res_timeout;

    logic              w_in_run;
    logic              w_grant;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_seq_wen;
    logic [7:0]        w_seq_wdata;

    // r_cnt holds (RUN cycle - 1); it is left unchanged on the exit cycle so
    // READ can report r_cnt+1 as the 1-based cycle on which Ack arrived.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_cnt         <= '0;
            r_lch         <= '0;
            r_res_data    <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_op_valid) begin
                        r_op    <= i_op_data;
                        r_state <= ST_LOAD_HI;
                    end
                end
                ST_LOAD_HI: r_state <= ST_LOAD_LO;
                ST_LOAD_LO: begin
                    r_cnt   <= '0;
                    r_lch   <= '0;
                    r_state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    if (r_lch == LCH_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_lch <= r_lch + LCH_W'(1);
                    end
                end
                ST_RUN: begin
                    if (i_cpu_ack) begin
                        r_state <= ST_READ;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res_timeout <= 1'b1;
                        r_res_data    <= '0;
                        r_res_cycles  <= CNT_TO;
                        r_state       <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_READ: begin
                    r_res_data    <= i_mem_rdata;
                    r_res_cycles  <= r_cnt + CNT_W'(1);
                    r_res_timeout <= 1'b0;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_in_run      = (r_state == ST_RUN);
    assign w_grant       = w_in_run ? GNT_CPU : GNT_SEQ;
    assign o_op_ready    = (r_state == ST_IDLE);
    assign o_res_valid   = (r_state == ST_RESP);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_cpu_start   = (r_state == ST_LAUNCH);
    assign o_cpu_reset   = !((r_state == ST_LAUNCH) || w_in_run);
    assign o_res_data    = r_res_data;
    assign o_res_cycles  = r_res_cycles;
    assign o_res_timeout = r_res_timeout;

    // Outside the two load states the sequencer only ever reads the result byte.
    always_comb begin
        w_seq_addr  = ADDR_W'(RES_ADDR);
        w_seq_wen   = 1'b0;
        w_seq_wdata = '0;
        case (r_state)
            ST_LOAD_HI: begin
                w_seq_addr  = ADDR_W'(OP_HI_ADDR);
                w_seq_wen   = 1'b1;
                w_seq_wdata = r_op[15:8];
            end
            ST_LOAD_LO: begin
                w_seq_addr  = ADDR_W'(OP_LO_ADDR);
                w_seq_wen   = 1'b1;
                w_seq_wdata = r_op[7:0];
            end
            default: ;
        endcase
    end

    dm_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_dm_mux (
        .i_grant     (w_grant),
        .i_seq_addr  (w_seq_addr),
        .i_seq_wen   (w_seq_wen),
        .i_seq_wdata (w_seq_wdata),
        .i_cpu_addr  (i_cpu_dm_addr),
        .i_cpu_wen   (i_cpu_dm_wen),
        .i_cpu_wdata (i_cpu_dm_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_rdata (o_cpu_dm_rdata)
    );

endmodule
